// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: writeback source codes,
// load type codes, FSM state encoding and the latched instruction record.
package wb_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;

  localparam logic [1:0] WDSEL_ALU = 2'b00;
  localparam logic [1:0] WDSEL_MEM = 2'b01;
  localparam logic [1:0] WDSEL_PC4 = 2'b10;
  localparam logic [1:0] WDSEL_RSV = 2'b11;

  localparam logic [2:0] DM_LW  = 3'b000;
  localparam logic [2:0] DM_LH  = 3'b001;
  localparam logic [2:0] DM_LHU = 3'b010;
  localparam logic [2:0] DM_LB  = 3'b011;
  localparam logic [2:0] DM_LBU = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_WAIT_MEM = 2'b01,
    S_COMMIT   = 2'b10
  } state_e;

  typedef struct packed {
    logic            rfwr;
    logic [RA_W-1:0] rd;
    logic [1:0]      wdsel;
    logic [2:0]      dmtype;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] pc;
  } wb_instr_t;

endpackage

// File: rtl/load_ext.sv
// Load data alignment and extension: picks the addressed byte/half of the
// read word and sign- or zero-extends it. Unknown load types pass the word.
module load_ext
  import wb_pkg::*;
(
  input  logic [2:0]      dmtype,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data_c
);

  logic [15:0] half_c;
  logic [7:0]  byte_c;

  assign half_c = rdata[{offset[1], 4'b0000} +: 16];
  assign byte_c = rdata[{offset, 3'b000} +: 8];

  always_comb begin
    data_c = rdata;
    case (dmtype)
      DM_LW:   data_c = rdata;
      DM_LH:   data_c = {{16{half_c[15]}}, half_c};
      DM_LHU:  data_c = {16'h0000, half_c};
      DM_LB:   data_c = {{24{byte_c[7]}}, byte_c};
      DM_LBU:  data_c = {24'h000000, byte_c};
      default: data_c = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts one instruction from MEM, waits for load data if
// needed, then commits it to the register file and counts retirements.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             m_valid,
  output logic             m_ready,
  input  logic             m_rfwr,
  input  logic [4:0]       m_rd,
  input  logic [1:0]       m_wdsel,
  input  logic [2:0]       m_dmtype,
  input  logic [31:0]      m_alu_out,
  input  logic [31:0]      m_pc,
  input  logic             dm_rvalid,
  input  logic [31:0]      dm_rdata,
  input  logic             freeze,
  input  logic             flush,
  output logic             RFWr,
  output logic [4:0]       A3,
  output logic [31:0]      WD,
  output logic [CNT_W-1:0] retired
);

  state_e          state_q, state_d;
  wb_instr_t       ins_q, ins_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic            ready_c;
  logic [XLEN-1:0] ext_c;
  logic [XLEN-1:0] wd_c;

  load_ext u_load_ext (
    .dmtype (ins_q.dmtype),
    .offset (ins_q.alu_out[1:0]),
    .rdata  (rdata_q),
    .data_c (ext_c)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      ins_q     <= '0;
      rdata_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ins_q     <= ins_d;
      rdata_q   <= rdata_d;
      retired_q <= retired_d;
    end
  end

  // Writeback data source for the latched instruction.
  always_comb begin
    wd_c = '0;
    case (ins_q.wdsel)
      WDSEL_ALU: wd_c = ins_q.alu_out;
      WDSEL_MEM: wd_c = ext_c;
      WDSEL_PC4: wd_c = ins_q.pc + 32'd4;
      WDSEL_RSV: wd_c = '0;
      default:   wd_c = '0;
    endcase
  end

  // Next state and outputs; freeze and reset suppress every side effect.
  always_comb begin
    state_d   = state_q;
    ins_d     = ins_q;
    rdata_d   = rdata_q;
    retired_d = retired_q;
    ready_c   = 1'b0;
    RFWr      = 1'b0;
    A3        = '0;
    WD        = '0;

    if (rstn && !freeze) begin
      case (state_q)
        S_IDLE: ready_c = !flush;
        S_WAIT_MEM: begin
          if (flush) begin
            state_d = S_IDLE;
          end else if (dm_rvalid) begin
            rdata_d = dm_rdata;
            state_d = S_COMMIT;
          end
        end
        S_COMMIT: begin
          ready_c   = 1'b1;
          RFWr      = ins_q.rfwr && (ins_q.rd != 5'd0);
          retired_d = retired_q + CNT_W'(1);
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      if (m_valid && ready_c) begin
        ins_d.rfwr    = m_rfwr;
        ins_d.rd      = m_rd;
        ins_d.wdsel   = m_wdsel;
        ins_d.dmtype  = m_dmtype;
        ins_d.alu_out = m_alu_out;
        ins_d.pc      = m_pc;
        state_d       = (m_wdsel == WDSEL_MEM) ? S_WAIT_MEM : S_COMMIT;
      end
    end

    if (rstn && state_q == S_COMMIT) begin
      A3 = ins_q.rd;
      WD = wd_c;
    end
  end

  assign m_ready = ready_c;
  assign retired = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, corner-case
// sequences and a randomized run against a transaction-level model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m_valid, m_rfwr, dm_rvalid, freeze, flush;
  logic [4:0]  m_rd;
  logic [1:0]  m_wdsel;
  logic [2:0]  m_dmtype;
  logic [31:0] m_alu_out, m_pc, dm_rdata;
  logic        m_ready, RFWr;
  logic [4:0]  A3;
  logic [31:0] WD, retired;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt;

  wb_stage #(.CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .m_valid(m_valid), .m_ready(m_ready),
    .m_rfwr(m_rfwr), .m_rd(m_rd), .m_wdsel(m_wdsel), .m_dmtype(m_dmtype),
    .m_alu_out(m_alu_out), .m_pc(m_pc), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata), .freeze(freeze), .flush(flush), .RFWr(RFWr),
    .A3(A3), .WD(WD), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference writeback value computed from the load/source rules.
  function automatic logic [31:0] ref_wd(input logic [1:0] sel, input logic [2:0] dt,
                                         input logic [31:0] alu, input logic [31:0] pc,
                                         input logic [31:0] rdat);
    logic [31:0] v;
    int off;
    off = int'(alu[1:0]);
    case (sel)
      2'd0: return alu;
      2'd2: return pc + 32'd4;
      2'd3: return 32'd0;
      default: begin
        if (dt == 3'd1 || dt == 3'd2) begin
          v = (rdat >> (16 * (off / 2))) & 32'h0000FFFF;
          if (dt == 3'd1 && v[15]) v = v | 32'hFFFF0000;
          return v;
        end else if (dt == 3'd3 || dt == 3'd4) begin
          v = (rdat >> (8 * off)) & 32'h000000FF;
          if (dt == 3'd3 && v[7]) v = v | 32'hFFFFFF00;
          return v;
        end
        return rdat;
      end
    endcase
  endfunction

  task automatic idle_inputs();
    m_valid = 0; m_rfwr = 0; m_rd = 0; m_wdsel = 0; m_dmtype = 0;
    m_alu_out = 0; m_pc = 0; dm_rvalid = 0; dm_rdata = 0; freeze = 0; flush = 0;
  endtask

  task automatic present(input logic [1:0] sel, input logic [2:0] dt, input logic wr,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc);
    m_valid = 1; m_wdsel = sel; m_dmtype = dt; m_rfwr = wr; m_rd = rd;
    m_alu_out = alu; m_pc = pc;
  endtask

  task automatic do_reset();
    @(negedge clk); idle_inputs(); rstn = 0;
    @(negedge clk);
    @(negedge clk); #1;
    exp_cnt = 0;
  endtask

  typedef struct {
    logic [1:0]  wdsel;
    logic [2:0]  dmtype;
    logic        rfwr;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        exp_rfwr;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[12];

  // Model state for the random phase.
  bit          p_valid, p_have;
  logic        p_rfwr;
  logic [4:0]  p_rd;
  logic [1:0]  p_sel;
  logic [2:0]  p_dt;
  logic [31:0] p_alu, p_pc, p_data;

  initial begin
    vecs[0]  = '{2'd0, 3'd0, 1'b1, 5'd5,  32'h0000_1234, 32'h0,         32'h0,         1'b1, 32'h0000_1234};
    vecs[1]  = '{2'd1, 3'd3, 1'b1, 5'd6,  32'h0000_0003, 32'h0,         32'h80FF_FFFF, 1'b1, 32'hFFFF_FF80};
    vecs[2]  = '{2'd1, 3'd4, 1'b1, 5'd6,  32'h0000_0003, 32'h0,         32'h80FF_FFFF, 1'b1, 32'h0000_0080};
    vecs[3]  = '{2'd1, 3'd1, 1'b1, 5'd8,  32'h0000_0002, 32'h0,         32'h8001_7FFF, 1'b1, 32'hFFFF_8001};
    vecs[4]  = '{2'd1, 3'd2, 1'b1, 5'd8,  32'h0000_0002, 32'h0,         32'h8001_7FFF, 1'b1, 32'h0000_8001};
    vecs[5]  = '{2'd2, 3'd0, 1'b1, 5'd1,  32'h0,         32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000};
    vecs[6]  = '{2'd2, 3'd0, 1'b1, 5'd0,  32'h0,         32'h0000_0100, 32'h0,         1'b0, 32'h0000_0104};
    vecs[7]  = '{2'd1, 3'd0, 1'b1, 5'd10, 32'h0000_0101, 32'h0,         32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    vecs[8]  = '{2'd1, 3'd7, 1'b1, 5'd11, 32'h0000_0002, 32'h0,         32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
    vecs[9]  = '{2'd1, 3'd3, 1'b1, 5'd12, 32'h0000_0000, 32'h0,         32'h1234_567F, 1'b1, 32'h0000_007F};
    vecs[10] = '{2'd3, 3'd0, 1'b1, 5'd7,  32'h0000_0055, 32'h0,         32'h0,         1'b1, 32'h0000_0000};
    vecs[11] = '{2'd0, 3'd0, 1'b0, 5'd3,  32'h0000_0ABC, 32'h0,         32'h0,         1'b0, 32'h0000_0ABC};

    idle_inputs();
    rstn = 0;
    exp_cnt = 0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_m_ready", 32'(m_ready), 32'd0);
    chk("rst_rfwr", 32'(RFWr), 32'd0);
    chk("rst_a3", 32'(A3), 32'd0);
    chk("rst_wd", WD, 32'd0);
    chk("rst_retired", retired, 32'd0);
    @(negedge clk); rstn = 1; #1;
    chk("idle_m_ready", 32'(m_ready), 32'd1);

    // Directed vectors: one instruction each, loads get data 2 cycles after accept.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      present(vecs[i].wdsel, vecs[i].dmtype, vecs[i].rfwr, vecs[i].rd, vecs[i].alu, vecs[i].pc);
      #1 chk($sformatf("v%0d_ready", i), 32'(m_ready), 32'd1);
      @(negedge clk); m_valid = 0;
      if (vecs[i].wdsel == 2'd1) begin
        #1 chk($sformatf("v%0d_wait_rfwr", i), 32'(RFWr), 32'd0);
        @(negedge clk); dm_rvalid = 1; dm_rdata = vecs[i].rdata;
        @(negedge clk); dm_rvalid = 0; dm_rdata = 32'h5A5A_5A5A;
      end
      #1;
      chk($sformatf("v%0d_rfwr", i), 32'(RFWr), 32'(vecs[i].exp_rfwr));
      chk($sformatf("v%0d_a3", i), 32'(A3), 32'(vecs[i].rd));
      chk($sformatf("v%0d_wd", i), WD, vecs[i].exp_wd);
      chk($sformatf("v%0d_retired_pre", i), retired, exp_cnt);
      exp_cnt++;
      @(negedge clk); #1;
      chk($sformatf("v%0d_after_rfwr", i), 32'(RFWr), 32'd0);
      chk($sformatf("v%0d_retired", i), retired, exp_cnt);
    end

    // Freeze held three cycles over a COMMIT.
    @(negedge clk); present(2'd0, 3'd0, 1'b1, 5'd9, 32'h0000_0999, 32'h0);
    @(negedge clk); m_valid = 0; freeze = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("frz_rfwr", 32'(RFWr), 32'd0);
      chk("frz_m_ready", 32'(m_ready), 32'd0);
      chk("frz_retired", retired, exp_cnt);
      @(negedge clk);
    end
    freeze = 0; #1;
    chk("unfrz_rfwr", 32'(RFWr), 32'd1);
    chk("unfrz_wd", WD, 32'h0000_0999);
    exp_cnt++;
    @(negedge clk); #1;
    chk("unfrz_single_pulse", 32'(RFWr), 32'd0);
    chk("unfrz_retired", retired, exp_cnt);

    // Flush and dm_rvalid together while waiting on a load.
    present(2'd1, 3'd0, 1'b1, 5'd4, 32'h0, 32'h0);
    @(negedge clk); m_valid = 0; flush = 1; dm_rvalid = 1; dm_rdata = 32'h1111_2222;
    #1 chk("flush_wait_rfwr", 32'(RFWr), 32'd0);
    @(negedge clk); flush = 0; dm_rvalid = 0; #1;
    chk("flush_rfwr", 32'(RFWr), 32'd0);
    chk("flush_a3", 32'(A3), 32'd0);
    chk("flush_idle_ready", 32'(m_ready), 32'd1);
    chk("flush_retired", retired, exp_cnt);
    @(negedge clk); #1;
    chk("flush_no_late_rfwr", 32'(RFWr), 32'd0);

    // Flush with m_valid in IDLE blocks acceptance.
    present(2'd0, 3'd0, 1'b1, 5'd2, 32'h77, 32'h0); flush = 1;
    #1 chk("idle_flush_ready", 32'(m_ready), 32'd0);
    @(negedge clk); m_valid = 0; flush = 0; #1;
    chk("idle_flush_rfwr", 32'(RFWr), 32'd0);
    chk("idle_flush_retired", retired, exp_cnt);

    // Back-to-back accepts through COMMIT.
    present(2'd0, 3'd0, 1'b1, 5'd20, 32'hA, 32'h0);
    @(negedge clk); present(2'd0, 3'd0, 1'b1, 5'd21, 32'hB, 32'h0);
    #1 chk("b2b_ready", 32'(m_ready), 32'd1);
    chk("b2b_a3_first", 32'(A3), 32'd20);
    @(negedge clk); m_valid = 0; #1;
    chk("b2b_rfwr_second", 32'(RFWr), 32'd1);
    chk("b2b_wd_second", WD, 32'hB);
    exp_cnt += 2;
    @(negedge clk); #1;
    chk("b2b_retired", retired, exp_cnt);

    // Reset asserted while in COMMIT.
    present(2'd0, 3'd0, 1'b1, 5'd4, 32'h44, 32'h0);
    @(negedge clk); m_valid = 0; rstn = 0; #1;
    chk("rstc_rfwr", 32'(RFWr), 32'd0);
    @(negedge clk); #1;
    chk("rstc_rfwr_next", 32'(RFWr), 32'd0);
    chk("rstc_a3", 32'(A3), 32'd0);
    chk("rstc_wd", WD, 32'd0);
    chk("rstc_m_ready", 32'(m_ready), 32'd0);
    chk("rstc_retired", retired, 32'd0);
    exp_cnt = 0;

    // Randomized traffic against the transaction model.
    do_reset();
    @(negedge clk); rstn = 1;
    p_valid = 0; p_have = 0;
    p_rfwr = 0; p_rd = 0; p_sel = 0; p_dt = 0; p_alu = 0; p_pc = 0; p_data = 0;
    for (int c = 0; c < 3000; c++) begin
      bit ready_inst, exp_ready, commit_now;
      logic [31:0] exp_wd;
      m_valid   = ($urandom_range(0, 1) == 1);
      m_rfwr    = ($urandom_range(0, 3) != 0);
      m_rd      = 5'($urandom_range(0, 31));
      m_wdsel   = 2'($urandom_range(0, 3));
      m_dmtype  = 3'($urandom_range(0, 7));
      m_alu_out = $urandom;
      m_pc      = $urandom;
      dm_rvalid = ($urandom_range(0, 2) == 0);
      dm_rdata  = $urandom;
      freeze    = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      #1;
      ready_inst = p_valid && (p_sel != 2'd1 || p_have);
      commit_now = ready_inst;
      exp_ready  = !freeze && (p_valid ? ready_inst : !flush);
      exp_wd     = commit_now ? ref_wd(p_sel, p_dt, p_alu, p_pc, p_data) : 32'd0;
      chk("rnd_m_ready", 32'(m_ready), 32'(exp_ready));
      chk("rnd_rfwr", 32'(RFWr), 32'(commit_now && !freeze && p_rfwr && p_rd != 5'd0));
      chk("rnd_a3", 32'(A3), commit_now ? 32'(p_rd) : 32'd0);
      chk("rnd_wd", WD, exp_wd);
      chk("rnd_retired", retired, exp_cnt);
      if (!freeze) begin
        if (p_valid && !ready_inst) begin
          if (flush) p_valid = 0;
          else if (dm_rvalid) begin p_have = 1; p_data = dm_rdata; end
        end else if (commit_now) begin
          exp_cnt++;
          p_valid = 0;
        end
        if (m_valid && exp_ready) begin
          p_valid = 1; p_have = 0; p_rfwr = m_rfwr; p_rd = m_rd; p_sel = m_wdsel;
          p_dt = m_dmtype; p_alu = m_alu_out; p_pc = m_pc;
        end
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 m_valid  in  1  MEM stage presents an instruction.
REQ-005 m_ready  out  1  wb_stage accepts the instruction this cycle.
REQ-006 m_rfwr  in  1  instruction writes a register.
REQ-007 m_rd  in  5  destination register.
REQ-008 m_wdsel  in  2  writeback source: 00 ALU, 01 MEM, 10 PC+4, 11 reserved.
REQ-009 m_dmtype  in  3  load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu.
REQ-010 m_alu_out  in  32  ALU result; bits [1:0] give the load byte offset.
REQ-011 m_pc  in  32  instruction PC.
REQ-012 dm_rvalid  in  1  data-memory read data valid.
REQ-013 dm_rdata  in  32  data-memory read word.
REQ-014 freeze  in  1  debug single-step hold; this is sw_i[1] at top level.
REQ-015 flush  in  1  discard an instruction that has not yet committed.
REQ-016 RFWr  out  1  register-file write enable.
REQ-017 A3  out  5  register-file write address.
REQ-018 WD  out  32  register-file write data.
REQ-019 retired  out  CNT_W  count of committed instructions.

Function
REQ-020 FSM states: IDLE, WAIT_MEM, COMMIT.
REQ-021 m_ready = 1 in IDLE or COMMIT when freeze=0; otherwise m_ready = 0.
REQ-022 When m_valid & m_ready, latch all m_* fields; the next state is WAIT_MEM if m_wdsel=01, else COMMIT.
REQ-023 WAIT_MEM: hold state until dm_rvalid=1; on that cycle latch dm_rdata and go to COMMIT. dm_rvalid is ignored in every other state.
REQ-024 COMMIT lasts exactly one cycle when freeze=0. The next state is WAIT_MEM or COMMIT if a new instruction is accepted that cycle, else IDLE.
REQ-025 RFWr = 1 only in COMMIT, and only when freeze=0, latched rfwr=1 and latched rd != 0. It is a one-cycle pulse per instruction.
REQ-026 A3 and WD are driven from the latched instruction in COMMIT. They are 0 in all other states.
REQ-027 Latency: a non-load accepted in cycle N produces RFWr in cycle N+1. For a load, dm_rvalid in cycle M produces RFWr in cycle M+1.
REQ-028 WD source:
  - ALU: alu_out.
  - MEM: extended load data.
  - PC+4: pc + 4, modulo 2^32.
  - reserved: 0.
REQ-029 Load extension:
  - lw: full word; offset ignored.
  - lh/lhu: half selected by offset[1] (0 = bits 15:0, 1 = bits 31:16); sign- or zero-extended.
  - lb/lbu: byte selected by offset[1:0]; sign- or zero-extended.
  - Undefined dmtype codes: treated as lw.
REQ-030 retired increments by 1 on every COMMIT cycle with freeze=0, including rd=0 and rfwr=0 instructions. It wraps from all-ones to 0.
REQ-031 freeze=1: state, latched fields and retired all hold, and RFWr=0. A COMMIT held under freeze commits on the first cycle freeze=0.
REQ-032 flush=1 in WAIT_MEM: go to IDLE, no write, no count. flush in COMMIT is ignored. flush has priority over dm_rvalid in the same cycle.
REQ-033 flush=1 with m_valid in IDLE: the instruction is not accepted and m_ready is forced 0.

Reset
REQ-034 While rstn=0 at a clock edge, the next state is:
  - state = IDLE, retired = 0, all latched fields = 0.
  - Outputs: RFWr=0, A3=0, WD=0, m_ready=0.
REQ-035 Reset in WAIT_MEM or COMMIT abandons the instruction with no write. The first accept is allowed on the cycle after rstn returns to 1.

Structure
REQ-036 Shared package wb_pkg holds the WDSel codes, DM type codes and FSM state encoding.
REQ-037 Sub-module load_ext is purely combinational: dmtype, offset, rdata -> 32-bit extended data.

Verification
REQ-038 ALU op, rd=5, alu_out=0x0000_1234 accepted in cycle N -> RFWr=1, A3=5, WD=0x0000_1234 in cycle N+1; retired=1.
REQ-039 lb, offset=3, dm_rdata=0x80FF_FFFF, dm_rvalid 2 cycles after accept -> WD=0xFFFF_FF80 one cycle after dm_rvalid; lbu gives 0x0000_0080.
REQ-040 lh, offset=2, dm_rdata=0x8001_7FFF -> WD=0xFFFF_8001; lhu gives 0x0000_8001.
REQ-041 PC+4 select with pc=0xFFFF_FFFC, rd=1 -> WD=0x0000_0000. rd=0 case: RFWr stays 0 and retired still increments.
REQ-042 freeze=1 for 3 cycles while in COMMIT -> no RFWr and m_ready=0 during freeze; a single RFWr pulse on the first cycle after freeze drops.
REQ-043 Load in WAIT_MEM with flush and dm_rvalid in the same cycle -> no RFWr, state IDLE, retired unchanged. Reset asserted in COMMIT -> no RFWr and all outputs 0 on the next cycle.
